// File: rtl/ex_alu_stage_pkg.sv
// Shared constants, opcodes, occupancy states and buffer entry layout for ex_alu_stage.
// Entry layout grows by three flag bits when EX_FLAGS_EN is defined.
package ex_alu_stage_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned OP_W = 3;
    localparam int unsigned RD_W = 5;

    typedef enum logic [OP_W-1:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_AND   = 3'b010,
        ALU_OR    = 3'b011,
        ALU_XOR   = 3'b100,
        ALU_SLT   = 3'b101,
        ALU_SLTU  = 3'b110,
        ALU_PASSB = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_ONE,
        OCC_FULL
    } occ_state_e;

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [RD_W-1:0] rd;
`ifdef EX_FLAGS_EN
        logic            zf;
        logic            cf;
        logic            of;
`endif
    } entry_t;

endpackage

// File: rtl/ex_alu_stage_alu_core.sv
// Combinational 64-bit ALU: (op, a, b) -> result and, with EX_FLAGS_EN, zf/cf/of.
// The subtractor is shared by SUB, SLT and SLTU.
module alu_core
    import ex_alu_stage_pkg::*;
(
    input  logic [OP_W-1:0] op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
`ifdef EX_FLAGS_EN
    output logic            zf,
    output logic            cf,
    output logic            of,
`endif
    output logic [XLEN-1:0] result
);

    logic [XLEN:0]   diff_ext;
    logic [XLEN-1:0] diff;
    logic [XLEN-1:0] sum;
    logic            borrow;
    logic            sub_of;
    logic            slt_bit;

    assign diff_ext = {1'b0, a} - {1'b0, b};
    assign diff     = diff_ext[XLEN-1:0];
    assign borrow   = diff_ext[XLEN];
    assign sub_of   = (a[XLEN-1] ^ b[XLEN-1]) & (diff[XLEN-1] ^ a[XLEN-1]);
    assign slt_bit  = diff[XLEN-1] ^ sub_of;

`ifdef EX_FLAGS_EN
    logic [XLEN:0] sum_ext;
    logic          add_of;

    assign sum_ext = {1'b0, a} + {1'b0, b};
    assign sum     = sum_ext[XLEN-1:0];
    assign add_of  = ~(a[XLEN-1] ^ b[XLEN-1]) & (sum[XLEN-1] ^ a[XLEN-1]);
`else
    assign sum = a + b;
`endif

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:   result = sum;
            ALU_SUB:   result = diff;
            ALU_AND:   result = a & b;
            ALU_OR:    result = a | b;
            ALU_XOR:   result = a ^ b;
            ALU_SLT:   result = {{(XLEN-1){1'b0}}, slt_bit};
            ALU_SLTU:  result = {{(XLEN-1){1'b0}}, borrow};
            ALU_PASSB: result = b;
            default:   result = '0;
        endcase
    end

`ifdef EX_FLAGS_EN
    always_comb begin
        zf = (result == '0);
        cf = 1'b0;
        of = 1'b0;
        if (op == ALU_ADD) begin
            cf = sum_ext[XLEN];
            of = add_of;
        end else if (op == ALU_SUB) begin
            cf = borrow;
            of = sub_of;
        end
    end
`endif

endmodule

// File: rtl/ex_alu_stage.sv
// Execute stage: valid/ready intake, ALU, 2-entry output skid buffer with flush.
// Define EX_FLAGS_EN to build the zf/cf/of outputs and their per-entry storage.
module ex_alu_stage
    import ex_alu_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic [RD_W-1:0] in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
`ifdef EX_FLAGS_EN
    output logic            out_zf,
    output logic            out_cf,
    output logic            out_of,
`endif
    output logic [RD_W-1:0] out_rd
);

    occ_state_e      state, state_nxt;
    entry_t          head_q, tail_q, new_entry;
    logic [XLEN-1:0] alu_result;
    logic            in_ready_q;
    logic            push, pop;
    logic            ld_head_new, ld_head_tail, ld_tail_new;

`ifdef EX_FLAGS_EN
    logic alu_zf, alu_cf, alu_of;
`endif

    alu_core u_alu (
        .op     (in_op),
        .a      (in_a),
        .b      (in_b),
`ifdef EX_FLAGS_EN
        .zf     (alu_zf),
        .cf     (alu_cf),
        .of     (alu_of),
`endif
        .result (alu_result)
    );

    always_comb begin
        new_entry        = '0;
        new_entry.result = alu_result;
        new_entry.rd     = in_rd;
`ifdef EX_FLAGS_EN
        new_entry.zf     = alu_zf;
        new_entry.cf     = alu_cf;
        new_entry.of     = alu_of;
`endif
    end

    assign push = in_valid && in_ready_q;
    assign pop  = out_valid && out_ready;

    // Flush only retargets the state; stale entry data is unreachable once EMPTY.
    always_comb begin
        state_nxt    = state;
        ld_head_new  = 1'b0;
        ld_head_tail = 1'b0;
        ld_tail_new  = 1'b0;
        if (flush) begin
            state_nxt = OCC_EMPTY;
        end else begin
            case (state)
                OCC_EMPTY: begin
                    if (push) begin
                        ld_head_new = 1'b1;
                        state_nxt   = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (push && pop) begin
                        ld_head_new = 1'b1;
                    end else if (push) begin
                        ld_tail_new = 1'b1;
                        state_nxt   = OCC_FULL;
                    end else if (pop) begin
                        state_nxt = OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (pop) begin
                        ld_head_tail = 1'b1;
                        state_nxt    = OCC_ONE;
                    end
                end
                default: state_nxt = OCC_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= OCC_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_nxt;
            in_ready_q <= (state_nxt != OCC_FULL);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            if (ld_head_new) begin
                head_q <= new_entry;
            end else if (ld_head_tail) begin
                head_q <= tail_q;
            end
            if (ld_tail_new) begin
                tail_q <= new_entry;
            end
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = (state != OCC_EMPTY);
    assign out_result = head_q.result;
    assign out_rd     = head_q.rd;
`ifdef EX_FLAGS_EN
    assign out_zf     = head_q.zf;
    assign out_cf     = head_q.cf;
    assign out_of     = head_q.of;
`endif

endmodule

// File: tb/tb_ex_alu_stage.sv
// Self-checking bench for ex_alu_stage: opcode vector table, corner-case sequences, random traffic.
// Flag checks are compiled in when EX_FLAGS_EN is defined.
module tb_ex_alu_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic [4:0]  out_rd;
`ifdef EX_FLAGS_EN
    logic        out_zf, out_cf, out_of;
`endif

    ex_alu_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_rd      (in_rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
`ifdef EX_FLAGS_EN
        .out_zf     (out_zf),
        .out_cf     (out_cf),
        .out_of     (out_of),
`endif
        .out_rd     (out_rd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  rd;
        logic        zf;
        logic        cf;
        logic        of;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        logic        zf;
        logic        cf;
        logic        of;
    } vec_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference ALU written from the opcode definitions with plain comparisons.
    function automatic exp_t ref_alu(input logic [2:0] op, input logic [63:0] a,
                                     input logic [63:0] b, input logic [4:0] rd);
        exp_t e;
        e.rd = rd;
        e.cf = 1'b0;
        e.of = 1'b0;
        case (op)
            3'd0: begin
                e.res = a + b;
                e.cf  = (e.res < a);
                e.of  = ($signed(a) >= 0 && $signed(b) >= 0 && $signed(e.res) < 0) ||
                        ($signed(a) < 0 && $signed(b) < 0 && $signed(e.res) >= 0);
            end
            3'd1: begin
                e.res = a - b;
                e.cf  = (a < b);
                e.of  = (($signed(a) < 0) != ($signed(b) < 0)) &&
                        (($signed(e.res) < 0) != ($signed(a) < 0));
            end
            3'd2: e.res = a & b;
            3'd3: e.res = a | b;
            3'd4: e.res = a ^ b;
            3'd5: e.res = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            3'd6: e.res = (a < b) ? 64'd1 : 64'd0;
            default: e.res = b;
        endcase
        e.zf = (e.res == 64'd0);
        return e;
    endfunction

    task automatic check_state();
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
        if (q.size() != 0) begin
            chk("out_result", out_result, q[0].res);
            chk("out_rd", 64'(out_rd), 64'(q[0].rd));
`ifdef EX_FLAGS_EN
            chk("out_flags", 64'({out_zf, out_cf, out_of}), 64'({q[0].zf, q[0].cf, q[0].of}));
`endif
        end
    endtask

    // Called at a negedge: drive, let one rising edge happen, update model, check at next negedge.
    task automatic cycle(input bit v, input logic [2:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] rd, input bit ordy, input bit fl);
        bit m_push, m_pop;
        in_valid  = v;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        in_rd     = rd;
        out_ready = ordy;
        flush     = fl;
        m_push = v && (q.size() < 2);
        m_pop  = ordy && (q.size() > 0);
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (m_pop) void'(q.pop_front());
            if (m_push) q.push_back(ref_alu(op, a, b, rd));
        end
        @(negedge clk);
        check_state();
    endtask

    task automatic idle(input bit ordy);
        cycle(1'b0, 3'd0, 64'd0, 64'd0, 5'd0, ordy, 1'b0);
    endtask

    vec_t tv[15];

    initial begin
        logic [63:0] ra, rb;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = '0;
        in_a = '0; in_b = '0; in_rd = '0; out_ready = 1'b0;

        tv[0]  = '{3'd0, 64'd5, 64'd7, 64'd12, 1'b0, 1'b0, 1'b0};
        tv[1]  = '{3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b1, 1'b0};
        tv[2]  = '{3'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1};
        tv[3]  = '{3'd1, 64'd5, 64'd5, 64'd0, 1'b1, 1'b0, 1'b0};
        tv[4]  = '{3'd1, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0};
        tv[5]  = '{3'd1, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1};
        tv[6]  = '{3'd2, 64'hF0F0, 64'hFF00, 64'hF000, 1'b0, 1'b0, 1'b0};
        tv[7]  = '{3'd3, 64'hF0F0, 64'h0F0F, 64'hFFFF, 1'b0, 1'b0, 1'b0};
        tv[8]  = '{3'd4, 64'hFFFF, 64'h00FF, 64'hFF00, 1'b0, 1'b0, 1'b0};
        tv[9]  = '{3'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 1'b0, 1'b0, 1'b0};
        tv[10] = '{3'd6, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b0, 1'b0};
        tv[11] = '{3'd5, 64'h8000_0000_0000_0000, 64'd1, 64'd1, 1'b0, 1'b0, 1'b0};
        tv[12] = '{3'd5, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 1'b0};
        tv[13] = '{3'd6, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b0};
        tv[14] = '{3'd7, 64'h1234, 64'hDEAD, 64'hDEAD, 1'b0, 1'b0, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_result", out_result, 64'd0);
        chk("rst_out_rd", 64'(out_rd), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Opcode table, one op per cycle with continuous drain
        for (int i = 0; i < 15; i++) begin
            cycle(1'b1, tv[i].op, tv[i].a, tv[i].b, 5'(i), 1'b1, 1'b0);
            chk($sformatf("vec%0d_result", i), out_result, tv[i].res);
`ifdef EX_FLAGS_EN
            chk($sformatf("vec%0d_flags", i), 64'({out_zf, out_cf, out_of}),
                64'({tv[i].zf, tv[i].cf, tv[i].of}));
`endif
        end
        idle(1'b1);

        // Backpressure: three back-to-back pushes with out_ready low
        cycle(1'b1, 3'd0, 64'd1, 64'd1, 5'd1, 1'b0, 1'b0);
        chk("bp_ready_after1", 64'(in_ready), 64'd1);
        cycle(1'b1, 3'd0, 64'd2, 64'd2, 5'd2, 1'b0, 1'b0);
        chk("bp_ready_after2", 64'(in_ready), 64'd0);
        cycle(1'b1, 3'd0, 64'd3, 64'd3, 5'd3, 1'b0, 1'b0);
        chk("bp_head_held", out_result, 64'd2);
        cycle(1'b1, 3'd0, 64'd3, 64'd3, 5'd3, 1'b1, 1'b0);
        chk("bp_second", out_result, 64'd4);
        cycle(1'b1, 3'd0, 64'd3, 64'd3, 5'd3, 1'b1, 1'b0);
        chk("bp_third", out_result, 64'd6);
        idle(1'b1);
        chk("bp_drained", 64'(out_valid), 64'd0);

        // Simultaneous push and pop in ONE
        cycle(1'b1, 3'd7, 64'd0, 64'd99, 5'd4, 1'b0, 1'b0);
        cycle(1'b1, 3'd0, 64'd5, 64'd7, 5'd5, 1'b1, 1'b0);
        chk("pp_head", out_result, 64'd12);
        idle(1'b0);
        chk("pp_count_one", 64'(in_ready), 64'd1);
        idle(1'b1);

        // Flush while FULL with a live input handshake
        cycle(1'b1, 3'd2, 64'hFF, 64'h0F, 5'd6, 1'b0, 1'b0);
        cycle(1'b1, 3'd3, 64'hF0, 64'h0F, 5'd7, 1'b0, 1'b0);
        cycle(1'b1, 3'd4, 64'hAA, 64'h55, 5'd8, 1'b0, 1'b1);
        chk("fl_out_valid", 64'(out_valid), 64'd0);
        chk("fl_in_ready", 64'(in_ready), 64'd1);
        idle(1'b1);
        chk("fl_no_ghost", 64'(out_valid), 64'd0);

        // Asynchronous reset mid-stream with two entries held
        cycle(1'b1, 3'd0, 64'd10, 64'd20, 5'd9, 1'b0, 1'b0);
        cycle(1'b1, 3'd0, 64'd30, 64'd40, 5'd10, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        chk("ar_out_valid", 64'(out_valid), 64'd0);
        chk("ar_out_result", out_result, 64'd0);
        chk("ar_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1'b1);

        // Random traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 3))
                0: ra = 64'h8000_0000_0000_0000;
                1: ra = 64'hFFFF_FFFF_FFFF_FFFF;
                default: ra = {$urandom, $urandom};
            endcase
            rb = ($urandom_range(0, 3) == 0) ? 64'(1) : {$urandom, $urandom};
            cycle($urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)), ra, rb,
                  5'($urandom_range(0, 31)), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 19) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
